dsp_mac_pipe: RTL

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dsp_mac_pipe.sv
// ---------------------------------------------------------------------------
// dsp_mac_pipe
//    Pipelined unsigned multiply-accumulate with valid/ready handshakes on
//    both sides. Stages 1..PIPELINE_DEPTH-1 carry the full-width product,
//    the clear flag and a valid bit. The final stage is the accumulator
//    itself. One global enable stalls every stage together whenever the
//    output holds an unconsumed result.
//
// Parameters
//    PIPELINE_DEPTH : register stages from accepted input to o (1..4)
//    WIDTH          : operand, accumulator and output width
//
// Ports
//    clk        : clock, rising edge
//    rst        : asynchronous active-high reset
//    in_valid   : a, b and clear carry an operation
//    in_ready   : operation accepted this cycle (combinational enable)
//    a, b       : unsigned multiplicand / multiplier
//    clear      : load accumulator with the product instead of adding
//    o          : accumulator value
//    out_valid  : o holds a result not yet consumed
//    out_ready  : consumer takes o this cycle
// ---------------------------------------------------------------------------
module dsp_mac_pipe #(
   parameter int PIPELINE_DEPTH = 3,
   parameter int WIDTH          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clear,
   output logic [WIDTH-1:0] o,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int PW = 2 * WIDTH;

   logic             en_s;
   logic [PW-1:0]    prod_in_s;
   logic [PW-1:0]    feed_prod_s;
   logic             feed_vld_s;
   logic             feed_clr_s;
   logic [WIDTH-1:0] acc_r;
   logic             acc_vld_r;
   logic             prod_hi_unused_s;

   // Global advance enable: the pipe moves unless a result is stuck at the output.
   always_comb begin
      en_s = (~acc_vld_r) | out_ready;
   end

   // Full-width product of the operands presented at the ports.
   always_comb begin
      prod_in_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   end

   assign in_ready  = en_s;
   assign o         = acc_r;
   assign out_valid = acc_vld_r;

   // Only the low half of the product is accumulated; the upper half is
   // carried through the stages but intentionally discarded here.
   assign prod_hi_unused_s = ^feed_prod_s[PW-1:WIDTH];

   generate
      if (PIPELINE_DEPTH == 1) begin : g_direct
         // With a single stage the accumulator is fed straight from the ports.
         assign feed_prod_s = prod_in_s;
         assign feed_vld_s  = in_valid;
         assign feed_clr_s  = clear;
      end else begin : g_stages
         localparam int S = PIPELINE_DEPTH - 1;

         logic [PW-1:0] prod_r [0:S-1];
         logic [S-1:0]  vld_r;
         logic [S-1:0]  clr_r;

         // Product/clear/valid shift register; bubbles shift exactly like data.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < S; i++) begin
                  prod_r[i] <= {PW{1'b0}};
               end
               vld_r <= {S{1'b0}};
               clr_r <= {S{1'b0}};
            end else if (en_s) begin
               prod_r[0] <= prod_in_s;
               vld_r[0]  <= in_valid;
               clr_r[0]  <= clear;
               for (int i = 1; i < S; i++) begin
                  prod_r[i] <= prod_r[i-1];
                  vld_r[i]  <= vld_r[i-1];
                  clr_r[i]  <= clr_r[i-1];
               end
            end else begin
               vld_r <= vld_r;
               clr_r <= clr_r;
            end
         end

         assign feed_prod_s = prod_r[S-1];
         assign feed_vld_s  = vld_r[S-1];
         assign feed_clr_s  = clr_r[S-1];
      end
   endgenerate

   // Accumulator stage: valid items load or add; a bubble keeps acc but drops out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r     <= {WIDTH{1'b0}};
         acc_vld_r <= 1'b0;
      end else if (en_s) begin
         acc_vld_r <= feed_vld_s;
         if (feed_vld_s) begin
            if (feed_clr_s) begin
               acc_r <= feed_prod_s[WIDTH-1:0];
            end else begin
               acc_r <= acc_r + feed_prod_s[WIDTH-1:0];
            end
         end else begin
            acc_r <= acc_r;
         end
      end else begin
         acc_r     <= acc_r;
         acc_vld_r <= acc_vld_r;
      end
   end

endmodule
